// File: rtl/decoder_pkg.sv
// decoder_pkg: shared FSM state type and one-hot helper for the scan decoder family.
package decoder_pkg;
  localparam int MAX_SEL = 8;
  localparam int MAX_OUT = 1 << MAX_SEL;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;
  function automatic int out_w(input int n);
    return 1 << n;
  endfunction
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL-1:0] idx, input int n);
    onehot = '0;
    if (int'(idx) < out_w(n)) onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/decoder_n_comb.sv
// decoder_n_comb: combinational N_SEL-to-2**N_SEL one-hot decode with enable.
module decoder_n_comb
  import decoder_pkg::*;
#(
  parameter int N_SEL = 3
) (
  input  logic                    en_i,
  input  logic [N_SEL-1:0]        a_i,
  output logic [(1<<N_SEL)-1:0]   y_o
);
  localparam int OUT_W = 1 << N_SEL;
  assign y_o = en_i ? OUT_W'(onehot(MAX_SEL'(a_i), N_SEL)) : '0;
endmodule

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered one-hot decoder with DIRECT decode and auto-advancing SCAN mode.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int N_SEL   = 3,
  parameter int DWELL_W = 8,
  parameter int ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E,
  input  logic                  mode,
  input  logic [N_SEL-1:0]      A,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<N_SEL)-1:0] Y,
  output logic [N_SEL-1:0]      cur_a,
  output logic                  wrap,
  output logic                  busy
);
  localparam int OUT_W = 1 << N_SEL;
  localparam logic [OUT_W-1:0] INACTIVE = (ACT_LOW != 0) ? '1 : '0;
  state_e             state_q, state_d;
  logic [N_SEL-1:0]   cur_a_q, cur_a_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   y_q, y_d, dec;
  // Next index is computed first so Y and cur_a always agree on the same edge.
  always_comb begin
    state_d = state_q;
    cur_a_d = cur_a_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    if (!E) state_d = IDLE;
    else if (!mode) begin
      state_d = DIRECT;
      cur_a_d = A;
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      cur_a_d = '0;
    end else if (cnt_q >= dwell) begin
      cur_a_d = cur_a_q + 1'b1;
      wrap_d  = &cur_a_q;
    end else cnt_d = cnt_q + 1'b1;
  end
  decoder_n_comb #(.N_SEL(N_SEL)) u_dec (
    .en_i(state_d != IDLE),
    .a_i (cur_a_d),
    .y_o (dec)
  );
  assign y_d = (ACT_LOW != 0) ? ~dec : dec;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_a_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= INACTIVE;
    end else begin
      state_q <= state_d;
      cur_a_q <= cur_a_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end
  assign Y     = y_q;
  assign cur_a = cur_a_q;
  assign wrap  = wrap_q;
  assign busy  = state_q == SCAN;
endmodule
